// File: rtl/injector.sv
// Local-port injection stage: queues local flits and places the FIFO head into the
// first free channel slot (N > S > E > W), registering all four channel slots.
module injector #(
  parameter int         DEPTH        = 4,
  parameter logic [2:0] ROUTER_ROW   = 3'd4,
  parameter logic [2:0] ROUTER_COL   = 3'd4,
  parameter int         STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] northad,
  input  logic [9:0] southad,
  input  logic [9:0] eastad,
  input  logic [9:0] westad,
  input  logic       n_vld,
  input  logic       s_vld,
  input  logic       e_vld,
  input  logic       w_vld,
  input  logic [9:0] lin_data,
  input  logic       lin_valid,
  output logic       lin_ready,
  output logic [9:0] nad,
  output logic [9:0] sad,
  output logic [9:0] ead,
  output logic [9:0] wad,
  output logic       n_ovld,
  output logic       s_ovld,
  output logic       e_ovld,
  output logic       w_ovld,
  output logic       inj_fire,
  output logic       inj_drop,
  output logic       starve
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [SW-1:0] starve_cnt_reg, starve_cnt_next;

  logic [9:0] head, inj_flit;
  logic [2:0] dir;
  logic       non_empty, all_busy, head_self, push, pop, inject;
  logic       sel_n, sel_s, sel_e, sel_w;

  assign lin_ready = (count_reg != CW'(DEPTH));
  assign push      = lin_valid && lin_ready;
  assign non_empty = (count_reg != '0);
  assign head      = mem[rd_ptr_reg];
  assign all_busy  = n_vld && s_vld && e_vld && w_vld;
  assign head_self = (head[5:3] == ROUTER_ROW) && (head[2:0] == ROUTER_COL);
  assign inject    = non_empty && !head_self && !all_busy;
  // A self-addressed head is discarded even when every slot is busy.
  assign pop       = non_empty && (head_self || !all_busy);

  always_comb begin
    dir = 3'b011;
    if (head[2:0] > ROUTER_COL)      dir = 3'b000;
    else if (head[2:0] < ROUTER_COL) dir = 3'b001;
    else if (head[5:3] > ROUTER_ROW) dir = 3'b010;
  end

  // The local flit's direction field is replaced by the computed route.
  assign inj_flit = (head & 10'h23F) | {1'b0, dir, 6'b0};

  assign sel_n = inject && !n_vld;
  assign sel_s = inject && n_vld && !s_vld;
  assign sel_e = inject && n_vld && s_vld && !e_vld;
  assign sel_w = inject && n_vld && s_vld && e_vld && !w_vld;

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (pop || !non_empty)
      starve_cnt_next = '0;
    else if (starve_cnt_reg != SW'(STARVE_LIMIT))
      starve_cnt_next = starve_cnt_reg + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= lin_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      starve_cnt_reg <= '0;
      starve         <= 1'b0;
      nad            <= '0;
      sad            <= '0;
      ead            <= '0;
      wad            <= '0;
      n_ovld         <= 1'b0;
      s_ovld         <= 1'b0;
      e_ovld         <= 1'b0;
      w_ovld         <= 1'b0;
      inj_fire       <= 1'b0;
      inj_drop       <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= AW'(wr_ptr_reg + 1'b1);
      if (pop)  rd_ptr_reg <= AW'(rd_ptr_reg + 1'b1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);
      starve_cnt_reg <= starve_cnt_next;
      starve         <= (starve_cnt_next == SW'(STARVE_LIMIT));
      nad      <= n_vld ? northad : (sel_n ? inj_flit : 10'b0);
      sad      <= s_vld ? southad : (sel_s ? inj_flit : 10'b0);
      ead      <= e_vld ? eastad  : (sel_e ? inj_flit : 10'b0);
      wad      <= w_vld ? westad  : (sel_w ? inj_flit : 10'b0);
      n_ovld   <= n_vld || sel_n;
      s_ovld   <= s_vld || sel_s;
      e_ovld   <= e_vld || sel_e;
      w_ovld   <= w_vld || sel_w;
      inj_fire <= inject;
      inj_drop <= non_empty && head_self;
    end
  end

endmodule

// File: tb/tb_injector.sv
// Directed bench for injector: hand-computed expected flits, one line per check.
module tb_injector;
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] northad, southad, eastad, westad;
  logic       n_vld, s_vld, e_vld, w_vld;
  logic [9:0] lin_data;
  logic       lin_valid, lin_ready;
  logic [9:0] nad, sad, ead, wad;
  logic       n_ovld, s_ovld, e_ovld, w_ovld;
  logic       inj_fire, inj_drop, starve;

  int checks = 0;
  int errors = 0;

  injector dut (
    .clk(clk), .rst(rst),
    .northad(northad), .southad(southad), .eastad(eastad), .westad(westad),
    .n_vld(n_vld), .s_vld(s_vld), .e_vld(e_vld), .w_vld(w_vld),
    .lin_data(lin_data), .lin_valid(lin_valid), .lin_ready(lin_ready),
    .nad(nad), .sad(sad), .ead(ead), .wad(wad),
    .n_ovld(n_ovld), .s_ovld(s_ovld), .e_ovld(e_ovld), .w_ovld(w_ovld),
    .inj_fire(inj_fire), .inj_drop(inj_drop), .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else
      $display("ok   %s = %0h", tag, got);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slots(input logic n, input logic s, input logic e, input logic w);
    n_vld = n; s_vld = s; e_vld = e; w_vld = w;
  endtask

  initial begin
    rst = 1'b1; lin_valid = 1'b0; lin_data = '0;
    northad = 10'h0A5; southad = 10'h155; eastad = 10'h2AA; westad = 10'h3C3;
    slots(0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    // Reset state
    chk("rst_nad", nad, 0);
    chk("rst_novld", n_ovld, 0);
    chk("rst_fire", inj_fire, 0);
    chk("rst_starve", starve, 0);
    chk("rst_ready", lin_ready, 1);

    // Corner destination, all slots empty -> north slot
    lin_data = 10'h23F; lin_valid = 1'b1;
    step();
    lin_valid = 1'b0;
    chk("lat_novld", n_ovld, 0);
    step();
    chk("inj1_nad", nad, 10'h23F);
    chk("inj1_novld", n_ovld, 1);
    chk("inj1_fire", inj_fire, 1);
    chk("inj1_sad", sad, 0);
    chk("inj1_ead", ead, 0);
    chk("inj1_wad", wad, 0);
    step();
    chk("inj1_fire_off", inj_fire, 0);

    // N,S occupied: row 1 col 4 goes south (011) into east slot
    slots(1, 1, 0, 0);
    lin_data = 10'h00C; lin_valid = 1'b1;
    step();
    lin_valid = 1'b0;
    step();
    chk("ns_nad", nad, 10'h0A5);
    chk("ns_sad", sad, 10'h155);
    chk("ns_ead", ead, 10'h0CC);
    chk("ns_eovld", e_ovld, 1);
    chk("ns_wovld", w_ovld, 0);

    // Starvation: all busy, flit row 4 col 0 (west) with junk dir bits
    slots(1, 1, 1, 1);
    lin_data = 10'h1E0; lin_valid = 1'b1;
    step();
    lin_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("starve_c%0d", k), starve, (k >= 8) ? 1 : 0);
    end
    chk("starve_nofire", inj_fire, 0);
    w_vld = 1'b0;
    step();
    chk("unstarve_wad", wad, 10'h060);
    chk("unstarve_wovld", w_ovld, 1);
    chk("unstarve_fire", inj_fire, 1);
    chk("unstarve_starve", starve, 0);
    chk("unstarve_ead", ead, 10'h2AA);

    // Fill FIFO with slots busy; pointers wrap
    w_vld = 1'b1;
    lin_valid = 1'b1;
    lin_data = 10'h027; step();   // A row4 col7 -> east
    lin_data = 10'h038; step();   // B row7 col0 -> west
    lin_data = 10'h034; step();   // C row6 col4 -> north
    lin_data = 10'h014; step();   // D row2 col4 -> south
    chk("full_ready", lin_ready, 0);
    lin_data = 10'h026;           // E row4 col6 -> east, held while full
    n_vld = 1'b0;
    step();
    chk("wrapA_nad", nad, 10'h027);
    chk("wrapA_ready", lin_ready, 1);
    step();                       // pop B and push E together
    chk("wrapB_nad", nad, 10'h078);
    chk("pushpop_ready", lin_ready, 1);
    n_vld = 1'b1;
    lin_data = 10'h021;           // F row4 col1 -> west
    step();
    chk("refull_ready", lin_ready, 0);
    lin_valid = 1'b0;
    n_vld = 1'b0;
    step(); chk("wrapC_nad", nad, 10'h0B4);
    step(); chk("wrapD_nad", nad, 10'h0D4);
    step(); chk("wrapE_nad", nad, 10'h026);
    step(); chk("wrapF_nad", nad, 10'h061);
    step();
    chk("drained_novld", n_ovld, 0);
    chk("drained_fire", inj_fire, 0);

    // Self-addressed flit is dropped
    slots(0, 0, 0, 0);
    lin_data = 10'h024; lin_valid = 1'b1;
    step();
    lin_valid = 1'b0;
    step();
    chk("self_drop", inj_drop, 1);
    chk("self_fire", inj_fire, 0);
    chk("self_novld", n_ovld, 0);
    step();
    chk("self_drop_off", inj_drop, 0);
    chk("self_empty_novld", n_ovld, 0);

    // Reset mid-operation
    slots(1, 1, 1, 1);
    lin_valid = 1'b1;
    lin_data = 10'h027; step();
    lin_data = 10'h038; step();
    lin_data = 10'h034; step();
    lin_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("mrst_nad", nad, 0);
    chk("mrst_novld", n_ovld, 0);
    chk("mrst_wovld", w_ovld, 0);
    chk("mrst_ready", lin_ready, 1);
    rst = 1'b0;
    slots(0, 0, 0, 0);
    step(); step();
    chk("mrst_nofire", inj_fire, 0);
    chk("mrst_noinj", n_ovld, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
